or_nibble_sequencer: RTL and testbench
======================================

Name: or_nibble_sequencer

Overview:
- Shares one 4-bit quad-OR gate unit (ls7432) between two requesters, each issuing WIDTH-bit OR operations.
- Round-robin arbitration between the requesters.
- Computes the wide OR nibble-serially, one nibble per clock, through the shared unit.
- Returns the assembled result with the ID of the requester that issued it.
- Sits between the CPU's logic-op issue paths and the shared chip-level OR unit.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4. N = WIDTH/4 nibble steps.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req1_valid  in  1  requester 1 has an operation.
- req1_ready  out  1  requester 1 operation accepted this cycle.
- req1_a  in  WIDTH  requester 1 operand A.
- req1_b  in  WIDTH  requester 1 operand B.
- gu_a  out  4  nibble of A driven to the shared OR unit.
- gu_b  out  4  nibble of B driven to the shared OR unit.
- gu_y  in  4  combinational OR-unit output for the current gu_a/gu_b.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_y  out  WIDTH  assembled result.
- res_id  out  1  requester that owns the result.
- busy  out  1  high in RUN or DONE.
- err  out  1  sticky self-check error (see Optional Feature).

Behaviour:
- Reset values: every output is 0, state is IDLE, step counter is 0, round-robin pointer favours requester 0.
- States and transitions:
  - IDLE: if either valid is high, grant one requester. The grant drives reqX_ready=1 combinationally in the same cycle. Capture a/b and the ID on that edge, then go to RUN with k=0.
  - RUN: drive gu_a = a_reg[4k+3:4k] and gu_b = b_reg[4k+3:4k]. At the edge, write gu_y into res_y[4k+3:4k] and increment k. When k = N-1, go to DONE.
  - DONE: res_valid=1; res_y and res_id are held stable. When res_ready=1 at the edge, return to IDLE with res_valid falling.
- Arbitration:
  - Only one valid high: grant it.
  - Both valid high: grant the requester not granted last. The pointer updates only on a grant.
- ready rules:
  - ready is never high outside IDLE.
  - At most one ready is high per cycle.
  - No new accept in the cycle DONE hands off; first accept is the cycle after the return to IDLE.
- Latency: accept at edge 0; res_valid high from edge N (N cycles in RUN). Throughput is one operation per N+2 cycles with res_ready held high.
- Data rules:
  - gu_a and gu_b are 0 in IDLE and DONE.
  - res_y is cleared when a new operation is accepted.
  - Requester operands may change after their accept without effect.
- res_ready with res_valid low is ignored.
- A valid dropped before grant is simply not serviced; no latching of unaccepted requests.
- Reset mid-RUN or mid-DONE aborts the operation: no result is delivered and all outputs return to reset values on the next edge.

Optional Feature:
- Macro: OR_NIBBLE_SEQUENCER_SELFCHECK_EN.
- Defined: each RUN cycle compares gu_y against the internal (gu_a | gu_b).
  - A mismatch sets err=1 at that edge.
  - err stays set (sticky) until rst.
  - The result is still the gu_y value.
- Undefined: err is tied to 0 and no comparator logic exists.

Decomposition:
- Package or_seq_pkg holds:
  - NIBBLE_W = 4.
  - State typedef (IDLE, RUN, DONE).
  - Requester-ID constants REQ0 = 0 and REQ1 = 1.
- Natural sub-module: rr_arb2, a two-way round-robin arbiter with a registered last-grant pointer. Its inputs are valid0/valid1/enable; its outputs are grant0/grant1.
- The sequencer instantiates rr_arb2. The shared OR unit stays outside this block.

Test Plan:
- Single request: WIDTH=16, the bench's OR model driving gu_y. After reset, req0 a=16'hA5C3, b=16'h5A3C → req0_ready pulse 1 cycle; gu_a sequence 3,C,5,A; res_valid at edge 4; res_y=16'hFFFF, res_id=0.
- Simultaneous requests: right after reset, req0 a=16'h1200/b=16'h0034 and req1 a=16'h8000/b=16'h0001 both held valid → req0 served first (res_y=16'h1234, id 0), then req1 (res_y=16'h8001, id 1). A second simultaneous pair is then served req0 first, then req1 (alternating).
- Backpressure: res_ready low 3 cycles in DONE with req1 valid → res_y/res_id stable, req1_ready stays 0; on handshake, req1 is accepted the next cycle.
- Reset mid-operation: rst at k=2 → next edge all outputs 0, state IDLE; no res_valid for the aborted operation; a following req0 completes normally.
- Self-check (macro defined): bench forces gu_y=4'h0 for the nibble with a=4'hF → err=1 after that edge, stays 1 across later correct operations, clears only on rst. Macro undefined: err stays 0.

Source files
------------

// File: rtl/or_nibble_sequencer_pkg.sv
// or_nibble_sequencer_pkg: shared constants and types for the OR nibble sequencer
//   NIBBLE_W   width of one step through the shared OR unit
//   state_t    sequencer states IDLE / RUN / DONE
//   REQ0/REQ1  requester IDs reported on res_id
package or_seq_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/or_nibble_sequencer_if.sv
// or_nibble_sequencer_if: request, shared-OR-unit and result signals of the sequencer
//   master: requesters, OR unit and result consumer (drives valids/operands, gu_y, res_ready)
//   slave : the sequencer (drives readies, gu_a/gu_b, result, busy, err)
interface or_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    import or_seq_pkg::*;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [NIBBLE_W-1:0] gu_a, gu_b, gu_y;
    logic res_valid, res_ready, res_id, busy, err;
    logic [WIDTH-1:0] res_y;
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, gu_y, res_ready,
        input  req0_ready, req1_ready, gu_a, gu_b, res_valid, res_y, res_id, busy, err
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, gu_y, res_ready,
        output req0_ready, req1_ready, gu_a, gu_b, res_valid, res_y, res_id, busy, err
    );
endinterface

// File: rtl/or_nibble_sequencer_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a registered last-grant pointer
//   clk, rst        clock, synchronous active-high reset
//   valid0, valid1  requests
//   enable          grants are only issued while enable is high
//   grant0, grant1  one-hot grant, combinational from the inputs
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic grant0,
    output logic grant1
);
    // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie
    logic last_q;
    assign grant0 = enable && valid0 && (!valid1 || last_q);
    assign grant1 = enable && valid1 && (!valid0 || !last_q);
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else if (grant0) last_q <= 1'b0;
        else if (grant1) last_q <= 1'b1;
    end
endmodule

// File: rtl/or_nibble_sequencer.sv
// or_nibble_sequencer: shares one 4-bit OR unit between two requesters, computing WIDTH-bit ORs nibble-serially
//   clk, rst  clock, synchronous active-high reset
//   bus       or_nibble_sequencer_if.slave: req0/req1 valid/ready/a/b, gu_a/gu_b/gu_y to the
//             shared OR unit, res_valid/res_ready/res_y/res_id, busy, err
//   WIDTH     operand width, multiple of 4 and >= 4; must match the interface WIDTH
//   OR_NIBBLE_SEQUENCER_SELFCHECK_EN  when defined, err flags gu_y != gu_a|gu_b during RUN (sticky)
module or_nibble_sequencer
    import or_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic clk,
    input logic rst,
    or_nibble_sequencer_if.slave bus
);
    localparam int N = WIDTH / NIBBLE_W;
    localparam int KW = N > 1 ? $clog2(N) : 1;
    state_t state_q;
    logic [KW-1:0] k_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic id_q, grant0, grant1, run;
    assign run = state_q == RUN;
    // Arbitration only while idle and out of reset, so ready never rises elsewhere
    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid0(bus.req0_valid),
        .valid1(bus.req1_valid),
        .enable(state_q == IDLE && !rst),
        .grant0(grant0),
        .grant1(grant1)
    );
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.gu_a = run ? a_q[NIBBLE_W*k_q +: NIBBLE_W] : '0;
    assign bus.gu_b = run ? b_q[NIBBLE_W*k_q +: NIBBLE_W] : '0;
    assign bus.res_valid = state_q == DONE;
    assign bus.busy = state_q != IDLE;
    assign bus.res_y = res_q;
    assign bus.res_id = id_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q <= '0;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            id_q <= REQ0;
        end else begin
            case (state_q)
                IDLE: if (grant0 || grant1) begin
                    a_q <= grant1 ? bus.req1_a : bus.req0_a;
                    b_q <= grant1 ? bus.req1_b : bus.req0_b;
                    id_q <= grant1 ? REQ1 : REQ0;
                    res_q <= '0;
                    k_q <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    res_q[NIBBLE_W*k_q +: NIBBLE_W] <= bus.gu_y;
                    k_q <= k_q + 1'b1;
                    if (k_q == KW'(N - 1)) begin
                        k_q <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: if (bus.res_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef OR_NIBBLE_SEQUENCER_SELFCHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else if (run && bus.gu_y != (bus.gu_a | bus.gu_b)) err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_or_nibble_sequencer.sv
// tb_or_nibble_sequencer: directed, scoreboard-checked bench for or_nibble_sequencer
module tb_or_nibble_sequencer;
    import or_seq_pkg::*;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic zap = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int n_res = 0;
    logic [W:0] sb[$];
    always #5 clk = ~clk;

    or_nibble_sequencer_if #(.WIDTH(W)) bus ();
    or_nibble_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // OR-unit model; zap corrupts any nibble whose A side is F
    assign bus.gu_y = (zap && bus.gu_a == 4'hF) ? 4'h0 : (bus.gu_a | bus.gu_b);

    function automatic logic [W-1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic z);
        logic [W-1:0] r;
        for (int i = 0; i < W / 4; i++)
            r[4*i +: 4] = (z && a[4*i +: 4] == 4'hF) ? 4'h0 : (a[4*i +: 4] | b[4*i +: 4]);
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst) begin
            if (bus.req0_ready) sb.push_back({REQ0, model(bus.req0_a, bus.req0_b, zap)});
            if (bus.req1_ready) sb.push_back({REQ1, model(bus.req1_a, bus.req1_b, zap)});
            if (bus.res_valid && bus.res_ready) begin
                n_res++;
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("res_id_y", {bus.res_id, bus.res_y}, e);
                end
            end
        end
    end

    task automatic issue0(logic [W-1:0] a, logic [W-1:0] b);
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        @(negedge clk);
        chk("acc0_ready", bus.req0_ready, 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    endtask

    task automatic wait_valid(string tag);
        for (int c = 0; c < 12 && !bus.res_valid; c++) @(negedge clk);
        chk(tag, bus.res_valid, 1);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ta, tb;
        int order[$];
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.res_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {bus.res_valid, bus.res_id, bus.busy, bus.err, bus.gu_a, bus.gu_b,
                            bus.req0_ready, bus.req1_ready}, 0);
        chk("rst_res_y", bus.res_y, 0);

        // single request
        ta = 16'hA5C3; tb = 16'h5A3C;
        bus.res_ready = 1'b1;
        issue0(ta, tb);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_gu_a", bus.gu_a, ta[4*i +: 4]);
            chk("t1_gu_b", bus.gu_b, tb[4*i +: 4]);
            chk("t1_run", {bus.busy, bus.res_valid, bus.req0_ready}, 3'b100);
        end
        @(negedge clk);
        chk("t1_done", {bus.res_valid, bus.res_id, bus.gu_a, bus.gu_b}, 10'b10_0000_0000);
        chk("t1_res_y", bus.res_y, 16'hFFFF);
        @(negedge clk);
        chk("t1_idle", {bus.res_valid, bus.busy}, 0);

        // simultaneous requests held valid: expect grants 0,1,0,1
        pulse_rst();
        bus.req0_valid = 1; bus.req0_a = 16'h1200; bus.req0_b = 16'h0034;
        bus.req1_valid = 1; bus.req1_a = 16'h8000; bus.req1_b = 16'h0001;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            chk("one_ready", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_ready) order.push_back(0);
            if (bus.req1_ready) order.push_back(1);
            @(posedge clk); #1;
            if (order.size() == 2) begin
                bus.req0_a = 16'h00F0; bus.req0_b = 16'h0F00;
                bus.req1_a = 16'hF000; bus.req1_b = 16'h000F;
            end
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        chk("rr_grants", order.size(), 4);
        foreach (order[i]) chk("rr_order", order[i], i % 2);
        repeat (8) @(negedge clk);

        // backpressure with req1 waiting
        bus.res_ready = 1'b0;
        issue0(16'h1111, 16'h2222);
        bus.req1_valid = 1; bus.req1_a = 16'h4000; bus.req1_b = 16'h0004;
        wait_valid("bp_wait");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_hold", {bus.res_valid, bus.res_id, bus.req1_ready}, 3'b100);
            chk("bp_res_y", bus.res_y, 16'h3333);
        end
        @(posedge clk); #1 bus.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_handoff", {bus.res_valid, bus.req1_ready}, 2'b10);
        @(negedge clk);
        chk("bp_next_acc", {bus.res_valid, bus.req1_ready}, 2'b01);
        @(posedge clk); #1 bus.req1_valid = 0;
        repeat (8) @(negedge clk);

        // reset at k=2 aborts the operation
        issue0(16'h000F, 16'h00F0);
        repeat (3) @(negedge clk);
        chk("abort_k2_gu_a", bus.gu_a, 4'h0);
        chk("abort_k2_gu_b", bus.gu_b, 4'h0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_outputs", {bus.res_valid, bus.res_id, bus.busy, bus.err, bus.gu_a, bus.gu_b,
                              bus.req0_ready, bus.req1_ready}, 0);
        chk("abort_res_y", bus.res_y, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_res", bus.res_valid, 0);
        end
        issue0(16'h0F0F, 16'hF0F0);
        wait_valid("post_abort_wait");
        repeat (2) @(negedge clk);

        // self-check: corrupt the F nibble, then a clean operation
        zap = 1'b1;
        issue0(16'h00F1, 16'h0000);
        wait_valid("sc_wait");
        @(posedge clk); #1 zap = 1'b0;
`ifdef OR_NIBBLE_SEQUENCER_SELFCHECK_EN
        chk("sc_err_set", bus.err, 1);
`else
        chk("sc_err_off", bus.err, 0);
`endif
        issue0(16'h1230, 16'h0004);
        wait_valid("sc2_wait");
        @(negedge clk);
`ifdef OR_NIBBLE_SEQUENCER_SELFCHECK_EN
        chk("sc_err_sticky", bus.err, 1);
`else
        chk("sc_err_off2", bus.err, 0);
`endif
        pulse_rst();
        @(negedge clk);
        chk("sc_err_clear", bus.err, 0);

        chk("n_results", n_res, 10);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
